// File: rtl/serial_mag_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator.
// State encoding and one-hot {alb, agb, aeb} result constants.
package serial_mag_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [2:0] RES_LT   = 3'b100;
    localparam logic [2:0] RES_GT   = 3'b010;
    localparam logic [2:0] RES_EQ   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

endpackage

// File: rtl/com.sv
// One-bit magnitude comparator cell.
// Exactly one of o_alb / o_agb / o_aeb is high for any input pair.
module com (
    input  logic i_a,
    input  logic i_b,
    output logic o_alb,
    output logic o_agb,
    output logic o_aeb
);

    assign o_alb = ~i_a &  i_b;
    assign o_agb =  i_a & ~i_b;
    assign o_aeb = ~(i_a ^ i_b);

endmodule

// File: rtl/serial_mag_cmp.sv
// Bit-serial MSB-first magnitude comparator built around one com cell.
// Define SERIAL_MAG_CMP_EARLY_EXIT_EN to stop at the first differing bit.
module serial_mag_cmp
    import serial_mag_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             alb,
    output logic             agb,
    output logic             aeb,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_res;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic             w_alb;
    logic             w_agb;
    logic             w_aeb;
    logic [2:0]       w_bit;
    logic             w_cnt_last;
    logic             w_last;
    logic [2:0]       w_final;

    com u_com (
        .i_a   (r_a[WIDTH-1]),
        .i_b   (r_b[WIDTH-1]),
        .o_alb (w_alb),
        .o_agb (w_agb),
        .o_aeb (w_aeb)
    );

    assign w_bit      = {w_alb, w_agb, w_aeb};
    assign w_cnt_last = (r_cnt == CW'(1));

`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
    assign w_last  = ~w_aeb | w_cnt_last;
    assign w_final = w_bit;
`else
    // First-difference flags {lt, gt}; later bits never overwrite them.
    logic [1:0] r_sticky;

    assign w_last  = w_cnt_last;
    assign w_final = (r_sticky != 2'b00) ? {r_sticky, 1'b0} : w_bit;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_res       <= RES_NONE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifndef SERIAL_MAG_CMP_EARLY_EXIT_EN
            r_sticky    <= 2'b00;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_cnt      <= CW'(WIDTH);
                        r_state    <= SHIFT;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
`ifndef SERIAL_MAG_CMP_EARLY_EXIT_EN
                        r_sticky   <= 2'b00;
`endif
                    end
                end
                SHIFT: begin
                    // Exit test precedes the decrement so r_cnt never wraps.
                    if (w_last) begin
                        r_state     <= DONE;
                        r_res       <= w_final;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_a   <= r_a << 1;
                        r_b   <= r_b << 1;
                        r_cnt <= r_cnt - CW'(1);
`ifndef SERIAL_MAG_CMP_EARLY_EXIT_EN
                        if (r_sticky == 2'b00) begin
                            r_sticky <= {w_alb, w_agb};
                        end
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_res       <= RES_NONE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_res       <= RES_NONE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign alb       = r_res[2];
    assign agb       = r_res[1];
    assign aeb       = r_res[0];

endmodule
